alu_sequencer: RTL and testbench
================================

# alu_sequencer

Instruction-driven sequencer that drives the 16-bit ALU's one-hot operation strobes and operand buses, then captures the ALU result bus. It owns a 16x16 register file. It accepts one encoded instruction per handshake, reads two source registers onto bus1/bus2, asserts exactly one ALU strobe, samples bus3, and writes the value back to the destination register. It sits between instruction fetch and the ALU, at the control end of the ALU interface.

## Interface
- DATA_W, 16, operand/register width; the bus width is fixed to the ALU and cannot be changed.
- REG_N, 16, register count; the 4-bit register fields are fixed.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction available.
- instr_ready  out  1  sequencer can accept an instruction; high only in IDLE.
- instr  in  16  instruction; [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2 (for LDI, [7:0] is the immediate).
- passthrough, add, sub, shr, shl, band, bor, bxor, bnegate  out  1 each  ALU one-hot strobes.
- bus1, bus2  out  16  ALU operands.
- bus3  in  16  ALU result.
- result_valid  out  1  one-cycle pulse when a register is written.
- result_rd  out  4  destination register of the write.
- result_data  out  16  value written.
- illegal  out  1  one-cycle pulse for an undefined opcode.
- dbg_addr  in  4  debug read address.
- dbg_data  out  16  combinational read of regs[dbg_addr].

## Operation
- Opcode map:
  - 0 NOP: no strobe, no write.
  - 1 ADD, 2 SUB, 3 SHR, 4 SHL, 5 AND, 6 OR, 7 XOR: bus1=regs[rs1], bus2=regs[rs2], corresponding strobe.
  - 8 NOT: bus1=regs[rs1], bus2=0, bnegate.
  - 9 LDI: rd <= {8'h00, instr[7:0]}; the ALU is not used.
  - 10–15: illegal.
- The `passthrough` output is never asserted; it is tied 0.
- FSM states: IDLE → OPERAND → EXECUTE → WRITEBACK → IDLE.
  - IDLE: instr_ready=1. On instr_valid, latch instr and go to OPERAND.
  - OPERAND: register bus1/bus2 from the register file.
  - EXECUTE: assert exactly one strobe and hold bus1/bus2. Sample bus3 into a result register at the end of the cycle.
  - WRITEBACK: write regs[rd]; pulse result_valid, result_rd, result_data.
- NOP, LDI and illegal opcodes still traverse all states, so every instruction takes a uniform 4 cycles.
  - No strobe is asserted for these opcodes.
  - LDI writes in WRITEBACK.
  - NOP has no write and no result_valid.
  - Illegal opcodes pulse `illegal` in WRITEBACK, with no write.
- Outside EXECUTE, all strobes are 0. bus1/bus2 are 0 except in OPERAND and EXECUTE.
- Wrap and width rules are the ALU's: ADD/SUB are modulo 2^16; shifts by ≥16 yield 0.
- rd may equal rs1 or rs2. Operands are read in OPERAND, so the old value is used.
- dbg_data reflects a write on the cycle after WRITEBACK.

## Timing
- Accept at edge N (instr_valid & instr_ready); OPERAND in cycle N+1; EXECUTE in N+2; WRITEBACK in N+3.
- The register is updated at the end of N+3. instr_ready is high again in N+4.
- Peak throughput: one instruction per 4 cycles.
- Reset values: all strobes 0, bus1/bus2 0, instr_ready 1 (the state is IDLE), result_valid 0, result_rd 0, result_data 0, illegal 0, all registers 0.
- Reset in any state aborts the in-flight instruction with no write and no pulse. Reset dominates a simultaneous instr_valid.
- instr is sampled only at the accepting edge; later changes are ignored.

## Configuration
- ALU_SEQ_FLAGS_EN defined:
  - Adds outputs flag_z and flag_n (1 bit each, reset 0).
  - They are updated only in WRITEBACK of ALU opcodes 1–8 and LDI: flag_z = (result==0), flag_n = result[15].
  - NOP and illegal opcodes leave the flags unchanged.
- Undefined: the flag ports and flag logic are absent. All other behaviour is identical.

## Structure
- Shared package alu_seq_pkg holds:
  - the opcode localparams (OP_NOP … OP_LDI);
  - the state encoding (S_IDLE, S_OPERAND, S_EXECUTE, S_WRITEBACK);
  - the instruction field bit positions.
- Sub-module reg_file16:
  - 16x16 registers, two combinational read ports plus one debug read port.
  - One synchronous write port with synchronous clear on rst.

## Test plan
- Reset, then LDI r1,0x05; LDI r2,0x03; ADD r3,r1,r2 → result_valid with result_rd=3, result_data=0x0008; dbg_addr=3 reads 0x0008; `add` high only in the EXECUTE cycle.
- r1=0x0000, r2=0x0001, SUB r4,r1,r2 → r4=0xFFFF (wrap); with ALU_SEQ_FLAGS_EN, flag_n=1 and flag_z=0.
- r1=0x8001, r2=0x0010, SHL r5,r1,r2 → r5=0x0000; with flags, flag_z=1. Also check that every strobe is one-hot or zero in every cycle.
- Opcode 0xC → `illegal` pulses at N+3, no result_valid, registers unchanged. Opcode 0 → no strobe and no write; instr_ready returns at N+4.
- Hold instr_valid continuously with 3 instructions → accepted at cycles 0, 4, 8. instr_ready is low for 3 cycles after each accept.
- Assert rst during EXECUTE of ADD r6 → no write, all outputs at reset values on the next cycle, r6=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcodes, FSM state encoding and instruction field positions for alu_sequencer
package alu_seq_pkg;
  localparam int DATA_W = 16;
  localparam int REG_N = 16;
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SHR = 4'd3;
  localparam logic [3:0] OP_SHL = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd8;
  localparam logic [3:0] OP_LDI = 4'd9;
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_OPERAND   = 2'd1;
  localparam logic [1:0] S_EXECUTE   = 2'd2;
  localparam logic [1:0] S_WRITEBACK = 2'd3;
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 0;
  localparam int IMM_W   = 8;
endpackage

// File: rtl/alu_sequencer_reg_file16.sv
// reg_file16: 16x16 register file, two operand read ports, one debug read port, one write port
module reg_file16
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [3:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        raddr1_i,
  input  logic [3:0]        raddr2_i,
  input  logic [3:0]        dbg_addr_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [DATA_W-1:0] dbg_data_o
);
  logic [DATA_W-1:0] regs_q [REG_N];
  assign rdata1_o = regs_q[raddr1_i];
  assign rdata2_o = regs_q[raddr2_i];
  assign dbg_data_o = regs_q[dbg_addr_i];
  // Clear every register on reset, otherwise take the single write port
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: 4-cycle instruction sequencer driving ALU strobes/buses; ALU_SEQ_FLAGS_EN adds flag_z/flag_n
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic        passthrough,
  output logic        add,
  output logic        sub,
  output logic        shr,
  output logic        shl,
  output logic        band,
  output logic        bor,
  output logic        bxor,
  output logic        bnegate,
  output logic [15:0] bus1,
  output logic [15:0] bus2,
  input  logic [15:0] bus3,
  output logic        result_valid,
  output logic [3:0]  result_rd,
  output logic [15:0] result_data,
  output logic        illegal,
  input  logic [3:0]  dbg_addr,
  output logic [15:0] dbg_data
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic        flag_z,
  output logic        flag_n
`endif
);
  logic [1:0]        state_q, state_d;
  logic [15:0]       instr_q;
  logic [DATA_W-1:0] op1_q, op2_q, res_q, rd1, rd2, opnd1, opnd2;
  logic [3:0]        opc, rd, rs1, rs2;
  logic              opd, exe, wb, alu_op, is_ldi, wr_en;
  // Decode the latched instruction and the current FSM phase
  always_comb begin
    opc = instr_q[OPC_LSB +: 4];
    rd = instr_q[RD_LSB +: 4];
    rs1 = instr_q[RS1_LSB +: 4];
    rs2 = instr_q[RS2_LSB +: 4];
    opd = state_q == S_OPERAND;
    exe = state_q == S_EXECUTE;
    wb = state_q == S_WRITEBACK;
    alu_op = opc != OP_NOP && opc <= OP_NOT;
    is_ldi = opc == OP_LDI;
    wr_en = wb && (alu_op || is_ldi);
    opnd1 = alu_op ? rd1 : '0;
    opnd2 = alu_op && opc != OP_NOT ? rd2 : '0;
  end
  // Fixed four-phase walk; only IDLE waits for a new instruction
  always_comb begin
    state_d = state_q == S_IDLE ? (instr_valid ? S_OPERAND : S_IDLE) :
              state_q == S_OPERAND ? S_EXECUTE :
              state_q == S_EXECUTE ? S_WRITEBACK : S_IDLE;
  end
  // Drive the ALU interface: buses live in OPERAND/EXECUTE, one strobe in EXECUTE only
  always_comb begin
    instr_ready = state_q == S_IDLE;
    bus1 = opd ? opnd1 : exe ? op1_q : '0;
    bus2 = opd ? opnd2 : exe ? op2_q : '0;
    passthrough = 1'b0;
    add = exe && opc == OP_ADD;
    sub = exe && opc == OP_SUB;
    shr = exe && opc == OP_SHR;
    shl = exe && opc == OP_SHL;
    band = exe && opc == OP_AND;
    bor = exe && opc == OP_OR;
    bxor = exe && opc == OP_XOR;
    bnegate = exe && opc == OP_NOT;
    result_valid = wr_en;
    result_rd = wr_en ? rd : '0;
    result_data = wr_en ? res_q : '0;
    illegal = wb && opc > OP_LDI;
  end
  // Sequencer state: instruction latch, held operands and captured result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      if (instr_ready && instr_valid) instr_q <= instr;
      if (opd) begin
        op1_q <= opnd1;
        op2_q <= opnd2;
      end
      if (exe) res_q <= is_ldi ? {{(DATA_W-IMM_W){1'b0}}, instr_q[IMM_W-1:0]} : bus3;
    end
  end
`ifdef ALU_SEQ_FLAGS_EN
  // Status flags follow every written result; NOP and illegal opcodes leave them alone
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (wr_en) begin
      flag_z <= res_q == '0;
      flag_n <= res_q[DATA_W-1];
    end
  end
`endif
  reg_file16 u_rf (
    .clk        (clk),
    .rst        (rst),
    .we_i       (wr_en),
    .waddr_i    (rd),
    .wdata_i    (res_q),
    .raddr1_i   (rs1),
    .raddr2_i   (rs2),
    .dbg_addr_i (dbg_addr),
    .rdata1_o   (rd1),
    .rdata2_o   (rd2),
    .dbg_data_o (dbg_data)
  );
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench with a behavioural ALU on bus1/bus2/bus3
module tb_alu_sequencer;
  logic        clk = 1'b0;
  logic        rst, instr_valid, instr_ready;
  logic [15:0] instr, bus1, bus2, bus3, result_data, dbg_data;
  logic        passthrough, add, sub, shr, shl, band, bor, bxor, bnegate;
  logic        result_valid, illegal;
  logic [3:0]  result_rd, dbg_addr;
  logic [7:0]  st;
  logic        mon = 1'b0;
  int          checks = 0;
  int          errors = 0;
`ifdef ALU_SEQ_FLAGS_EN
  logic        flag_z, flag_n;
`endif

  alu_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .passthrough  (passthrough),
    .add          (add),
    .sub          (sub),
    .shr          (shr),
    .shl          (shl),
    .band         (band),
    .bor          (bor),
    .bxor         (bxor),
    .bnegate      (bnegate),
    .bus1         (bus1),
    .bus2         (bus2),
    .bus3         (bus3),
    .result_valid (result_valid),
    .result_rd    (result_rd),
    .result_data  (result_data),
    .illegal      (illegal),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .flag_z       (flag_z),
    .flag_n       (flag_n)
`endif
  );

  always #5 clk = ~clk;

  assign st = {bnegate, bxor, bor, band, shl, shr, sub, add};

  always_comb begin
    bus3 = add ? bus1 + bus2 :
           sub ? bus1 - bus2 :
           shr ? (bus2 >= 16'd16 ? 16'h0000 : bus1 >> bus2) :
           shl ? (bus2 >= 16'd16 ? 16'h0000 : bus1 << bus2) :
           band ? bus1 & bus2 :
           bor ? bus1 | bus2 :
           bxor ? bus1 ^ bus2 :
           bnegate ? ~bus1 : 16'h0000;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon) begin
      chk("strobe_onehot0", 32'($onehot0(st)), 32'd1);
      chk("passthrough_zero", 32'(passthrough), 32'd0);
    end
  end

  task automatic run(input logic [15:0] ins, input logic ev, input logic [15:0] ed,
                     input logic eill, input logic [15:0] eb1, input logic [15:0] eb2);
    logic [3:0]  op;
    logic [7:0]  emask;
    logic [15:0] old;
    op = ins[15:12];
    emask = (op >= 4'd1 && op <= 4'd8) ? 8'(8'd1 << (op - 4'd1)) : 8'h00;
    dbg_addr = ins[11:8];
    #1;
    old = dbg_data;
    chk("ready_idle", 32'(instr_ready), 32'd1);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = ~ins;
    chk("ready_operand", 32'(instr_ready), 32'd0);
    chk("strobe_operand", 32'(st), 32'd0);
    if (emask != 8'h00) begin
      chk("bus1_operand", 32'(bus1), 32'(eb1));
      chk("bus2_operand", 32'(bus2), 32'(eb2));
    end
    @(posedge clk); #1;
    chk("ready_execute", 32'(instr_ready), 32'd0);
    chk("strobe_execute", 32'(st), 32'(emask));
    if (emask != 8'h00) begin
      chk("bus1_execute", 32'(bus1), 32'(eb1));
      chk("bus2_execute", 32'(bus2), 32'(eb2));
    end
    @(posedge clk); #1;
    chk("ready_wb", 32'(instr_ready), 32'd0);
    chk("strobe_wb", 32'(st), 32'd0);
    chk("bus1_wb", 32'(bus1), 32'd0);
    chk("bus2_wb", 32'(bus2), 32'd0);
    chk("result_valid_wb", 32'(result_valid), 32'(ev));
    chk("illegal_wb", 32'(illegal), 32'(eill));
    if (ev) begin
      chk("result_rd_wb", 32'(result_rd), 32'(ins[11:8]));
      chk("result_data_wb", 32'(result_data), 32'(ed));
    end
    @(posedge clk); #1;
    chk("ready_back", 32'(instr_ready), 32'd1);
    chk("result_valid_after", 32'(result_valid), 32'd0);
    chk("illegal_after", 32'(illegal), 32'd0);
    chk("dbg_after", 32'(dbg_data), ev ? 32'(ed) : 32'(old));
  endtask

  task automatic flags(input logic ez, input logic en);
`ifdef ALU_SEQ_FLAGS_EN
    chk("flag_z", 32'(flag_z), 32'(ez));
    chk("flag_n", 32'(flag_n), 32'(en));
`else
    chk("flags_absent_idle", 32'(instr_ready), 32'(ez | en | 1'b1));
`endif
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 16'h0000;
    dbg_addr = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_strobes", 32'(st), 32'd0);
    chk("rst_passthrough", 32'(passthrough), 32'd0);
    chk("rst_bus1", 32'(bus1), 32'd0);
    chk("rst_bus2", 32'(bus2), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_result_rd", 32'(result_rd), 32'd0);
    chk("rst_result_data", 32'(result_data), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      @(posedge clk); #1;
      chk("rst_reg", 32'(dbg_data), 32'd0);
    end
    flags(1'b0, 1'b0);
    rst = 1'b0;
    mon = 1'b1;
    run(16'h9105, 1'b1, 16'h0005, 1'b0, 16'h0, 16'h0);
    run(16'h9203, 1'b1, 16'h0003, 1'b0, 16'h0, 16'h0);
    run(16'h1312, 1'b1, 16'h0008, 1'b0, 16'h0005, 16'h0003);
    run(16'h9100, 1'b1, 16'h0000, 1'b0, 16'h0, 16'h0);
    run(16'h9201, 1'b1, 16'h0001, 1'b0, 16'h0, 16'h0);
    run(16'h2412, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'h0001);
    flags(1'b0, 1'b1);
    run(16'h9180, 1'b1, 16'h0080, 1'b0, 16'h0, 16'h0);
    run(16'h9708, 1'b1, 16'h0008, 1'b0, 16'h0, 16'h0);
    run(16'h4117, 1'b1, 16'h8000, 1'b0, 16'h0080, 16'h0008);
    run(16'h9801, 1'b1, 16'h0001, 1'b0, 16'h0, 16'h0);
    run(16'h6118, 1'b1, 16'h8001, 1'b0, 16'h8000, 16'h0001);
    flags(1'b0, 1'b1);
    run(16'h9210, 1'b1, 16'h0010, 1'b0, 16'h0, 16'h0);
    run(16'h8910, 1'b1, 16'h7FFE, 1'b0, 16'h8001, 16'h0000);
    run(16'h7A13, 1'b1, 16'h8009, 1'b0, 16'h8001, 16'h0008);
    run(16'h5B18, 1'b1, 16'h0001, 1'b0, 16'h8001, 16'h0001);
    run(16'h3C17, 1'b1, 16'h0080, 1'b0, 16'h8001, 16'h0008);
    run(16'h4512, 1'b1, 16'h0000, 1'b0, 16'h8001, 16'h0010);
    flags(1'b1, 1'b0);
    run(16'hC123, 1'b0, 16'h0000, 1'b1, 16'h0, 16'h0);
    flags(1'b1, 1'b0);
    run(16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0, 16'h0);
    flags(1'b1, 1'b0);
    instr_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      chk("b2b_ready", 32'(instr_ready), 32'((c % 4) == 0));
      instr = c < 4 ? 16'h9D11 : c < 8 ? 16'h9E22 : 16'h1FDE;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    dbg_addr = 4'd15;
    #1;
    chk("b2b_r15", 32'(dbg_data), 32'h0033);
    instr = 16'h1618;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_add_exec", 32'(add), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", 32'(instr_ready), 32'd1);
    chk("abort_strobes", 32'(st), 32'd0);
    chk("abort_bus1", 32'(bus1), 32'd0);
    chk("abort_bus2", 32'(bus2), 32'd0);
    chk("abort_result_valid", 32'(result_valid), 32'd0);
    chk("abort_result_rd", 32'(result_rd), 32'd0);
    chk("abort_result_data", 32'(result_data), 32'd0);
    chk("abort_illegal", 32'(illegal), 32'd0);
    flags(1'b0, 1'b0);
    dbg_addr = 4'd6;
    #1;
    chk("abort_r6", 32'(dbg_data), 32'd0);
    dbg_addr = 4'd1;
    #1;
    chk("abort_r1_cleared", 32'(dbg_data), 32'd0);
    @(posedge clk); #1;
    chk("abort_no_late_write", 32'(result_valid), 32'd0);
    chk("abort_idle_stays", 32'(instr_ready), 32'd1);
    dbg_addr = 4'd6;
    #1;
    chk("abort_r6_later", 32'(dbg_data), 32'd0);
    mon = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
